mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-memory port. Accepts one load/store per handshake from the
//  CPU execute stage and generates byte enables and lane-replicated store data. Drives the
//  memory's read/write addresses and write enable for the time the memory needs, then
//  extracts and sign/zero-extends load data from q. Sits between the CPU pipeline and datamem.
// PARAMETERS
//  ADDR_W   15  word-address width driven to memory (req_addr[ADDR_W+1:2])
//  RD_LAT    4  clk cycles rdaddress is held before q is sampled (>=1)
//  WR_HOLD   4  clk cycles wren/wraddress/data/byteena are held per store (>=1)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  req_valid      in   1       request present
//  req_ready      out  1       unit idle; request accepted when req_valid & req_ready
//  req_we         in   1       1=store, 0=load
//  req_funct3     in   3       0=B 1=H 2=W 4=BU 5=HU (BU/HU loads only)
//  req_addr       in   32      byte address
//  req_wdata      in   32      store data, right-aligned
//  resp_valid     out  1       one-cycle completion pulse
//  resp_rdata     out  32      extended load data; 0 for stores and errors
//  resp_err       out  1       misaligned or illegal request; qualified by resp_valid
//  mem_rdaddress  out  ADDR_W  memory read word address
//  mem_wraddress  out  ADDR_W  memory write word address
//  mem_wren       out  1       memory write enable
//  mem_byteena    out  4       memory byte enables
//  mem_data       out  32      memory write data
//  mem_q          in   32      memory read data
// BEHAVIOUR
//  - Reset (async): state IDLE, counter 0, every output 0 except req_ready=1.
//    A reset mid-operation aborts the access and drops mem_wren immediately.
//  - FSM: IDLE -> RD_WAIT (load) | WR_HOLD (store) | RESP (error); RD_WAIT, WR_HOLD -> RESP;
//    RESP -> IDLE. req_ready=1 only in IDLE. resp_valid=1 only in RESP, for exactly 1 cycle.
//    No back-pressure on the response.
//  - Accept: latch we/funct3/addr/wdata. Word addr = addr[ADDR_W+1:2], driven to both
//    mem_rdaddress and mem_wraddress and held constant until return to IDLE.
//  - Error: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {3,6,7}, or store with
//    funct3 4/5. Goes straight to RESP with resp_err=1 and rdata=0. Memory is not touched
//    and mem_wren stays 0.
//  - Load: RD_WAIT lasts RD_LAT cycles. mem_q is captured on the last RD_WAIT cycle.
//    Latency from accept to resp_valid = RD_LAT+1 cycles. Lane = addr[1:0] for B/BU and
//    addr[1] for H/HU. B/H sign-extend; BU/HU zero-extend; W passes through.
//  - Store: mem_wren=1 for exactly WR_HOLD cycles (all of WR_HOLD), then RESP.
//    Byteena: B=4'b0001<<addr[1:0], H=4'b0011<<{addr[1],1'b0}, W=4'b1111.
//    mem_data: B={4{wdata[7:0]}}, H={2{wdata[15:0]}}, W=wdata.
//  - Outside WR_HOLD: mem_wren=0, mem_byteena=0, mem_data=0. Counter saturates; no wrap.
//  - A request presented while busy is held by the requester (req_ready=0); no request is lost.
//  - A new request may be accepted the cycle after RESP (in IDLE).
// STRUCTURE
//  - Package mem_access_pkg: funct3 constants F3_B/H/W/BU/HU, state enum
//    {IDLE,RD_WAIT,WR_HOLD,RESP}, byteena/lane helper functions.
//  - Sub-module mem_load_align (combinational): mem_q, funct3, addr[1:0] -> extended rdata.
//    FSM, counter and store lane steering stay in the top.
// TESTING
//  1 sw 0x11223344 @0x8 -> byteena=1111, wraddress=2, wren high 4 cycles; then
//    lw @0x8 -> rdata=0x11223344 at accept+5.
//  2 sb 0xAB @0x0D -> byteena=0010, data=0xABABABAB; lb @0x0D -> 0xFFFFFFAB;
//    lbu -> 0x000000AB.
//  3 sh 0x8001 @0x12 -> byteena=1100; lh -> 0xFFFF8001; lhu -> 0x00008001.
//  4 lw @0x6, sh @0x3, funct3=3 -> resp_err=1 one cycle after accept, wren never asserted.
//  5 back-to-back req_valid held high: req_ready low while busy, each request completes in order.
//  6 rst asserted on the 2nd WR_HOLD cycle -> mem_wren=0 same cycle, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory initiator: funct3 encodings,
// FSM states and the store lane-steering / legality functions.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_HOLD,
    RESP
  } state_e;

  // Misaligned halfword/word, undefined funct3, or an unsigned-width store.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 1'b0;
      F3_H:    return addr_lo[0];
      F3_W:    return addr_lo != 2'b00;
      F3_BU:   return we;
      F3_HU:   return we | addr_lo[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_byteena(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 4'b0001 << addr_lo;
      F3_H:    return 4'b0011 << {addr_lo[1], 1'b0};
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3,
                                              input logic [31:0] wdata);
    case (funct3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      F3_W:    return wdata;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a memory read word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_q,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_q[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_q[31:16] : mem_q[15:0];
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata = mem_q;
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: accepts one load/store per handshake, holds the memory
// addresses/strobes for the required cycles and returns an aligned load result.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int RD_LAT  = 4,
  parameter int WR_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic              mem_wren,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  input  logic [31:0]       mem_q
);

  localparam int CNT_MAX = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The WR_HOLD parameter shadows the imported state literal, so states are
  // always referenced through the package scope here.
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  mem_load_align u_load_align (
    .mem_q   (mem_q),
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= mem_access_pkg::IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      mem_access_pkg::IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[ADDR_W+1:0];
          wdata_d  = req_wdata;
          err_d    = is_illegal(req_we, req_funct3, req_addr[1:0]);
          rdata_d  = 32'h0;
          if (err_d)       state_d = mem_access_pkg::RESP;
          else if (req_we) state_d = mem_access_pkg::WR_HOLD;
          else             state_d = mem_access_pkg::RD_WAIT;
        end
      end
      mem_access_pkg::RD_WAIT: begin
        // q has been stable for RD_LAT cycles of held rdaddress by now.
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          rdata_d = load_data;
          state_d = mem_access_pkg::RESP;
        end
      end
      mem_access_pkg::WR_HOLD: begin
        if (cnt_q == CNT_W'(WR_HOLD - 1)) state_d = mem_access_pkg::RESP;
      end
      mem_access_pkg::RESP: state_d = mem_access_pkg::IDLE;
      default:              state_d = mem_access_pkg::IDLE;
    endcase
  end

  assign mem_rdaddress = addr_q[ADDR_W+1:2];
  assign mem_wraddress = addr_q[ADDR_W+1:2];

  always_comb begin
    req_ready   = (state_q == mem_access_pkg::IDLE);
    resp_valid  = (state_q == mem_access_pkg::RESP);
    resp_err    = resp_valid & err_q;
    resp_rdata  = resp_valid ? rdata_q : 32'h0;
    mem_wren    = 1'b0;
    mem_byteena = 4'b0000;
    mem_data    = 32'h0;
    if (state_q == mem_access_pkg::WR_HOLD) begin
      mem_wren    = 1'b1;
      mem_byteena = store_byteena(funct3_q, addr_q[1:0]);
      mem_data    = store_lanes(funct3_q, wdata_q);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a byte-enabled memory model
// that registers q once per cycle from the held read address.
module tb_mem_access_unit;

  localparam int ADDR_W = 15;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_rdaddress;
  logic [ADDR_W-1:0] mem_wraddress;
  logic              mem_wren;
  logic [3:0]        mem_byteena;
  logic [31:0]       mem_data;
  logic [31:0]       mem_q;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_rdaddress (mem_rdaddress),
    .mem_wraddress (mem_wraddress),
    .mem_wren      (mem_wren),
    .mem_byteena   (mem_byteena),
    .mem_data      (mem_data),
    .mem_q         (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_model [0:255];
  always @(posedge clk) begin
    if (mem_wren)
      for (int k = 0; k < 4; k++)
        if (mem_byteena[k]) mem_model[mem_wraddress[7:0]][8*k +: 8] <= mem_data[8*k +: 8];
    mem_q <= mem_model[mem_rdaddress[7:0]];
  end

  typedef struct {
    logic              err;
    logic [31:0]       rdata;
    int                lat;
    int                wren_cyc;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [ADDR_W-1:0] waddr;
    int                acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [31:0] rdata, input int lat,
                              input int wren_cyc, input logic [3:0] be,
                              input logic [31:0] wd, input int waddr);
    exp_t e;
    e.err = err; e.rdata = rdata; e.lat = lat; e.wren_cyc = wren_cyc;
    e.be = be; e.wd = wd; e.waddr = ADDR_W'(waddr); e.acc = 0;
    return e;
  endfunction

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
  endtask

  // Waits for the handshake edge; records the accept cycle and pushes the expectation.
  task automatic wait_accept(input string tag, input exp_t e, input bit push);
    bit rdy;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    check({tag, " accepted"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, " ready_low_busy"}, 32'(req_ready), 32'd0);
      e.acc = cyc - 1;
      if (push) sb.push_back(e);
    end
  endtask

  task automatic wait_resp(input string tag);
    exp_t e;
    int   wc;
    bit   seen;
    if (sb.size() == 0) begin
      check({tag, " sb_size"}, 32'(sb.size()), 32'd1);
      return;
    end
    e    = sb.pop_front();
    wc   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_wren) begin
        if (wc == 0) begin
          check({tag, " byteena"}, 32'(mem_byteena), 32'(e.be));
          check({tag, " data"}, mem_data, e.wd);
          check({tag, " wraddress"}, 32'(mem_wraddress), 32'(e.waddr));
        end
        wc++;
      end
      if (resp_valid) begin
        seen = 1'b1;
        check({tag, " err"}, 32'(resp_err), 32'(e.err));
        check({tag, " rdata"}, resp_rdata, e.rdata);
        check({tag, " resp_cycle"}, 32'(cyc), 32'(e.acc + e.lat));
        check({tag, " wren_cycles"}, 32'(wc), 32'(e.wren_cyc));
      end
    end
    check({tag, " resp_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, " pulse_one_cycle"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic single(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
    present(we, f3, addr, wdata);
    wait_accept(tag, e, 1'b1);
    req_valid = 1'b0;
    wait_resp(tag);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst wren", 32'(mem_wren), 32'd0);
    check("rst byteena", 32'(mem_byteena), 32'd0);
    check("rst data", mem_data, 32'h0);
    check("rst rdaddress", 32'(mem_rdaddress), 32'd0);
    check("rst wraddress", 32'(mem_wraddress), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store/load.
    single("sw", 1'b1, 3'd2, 32'h8, 32'h11223344, mk(1'b0, 32'h0, 5, 4, 4'b1111, 32'h11223344, 2));
    single("lw", 1'b0, 3'd2, 32'h8, 32'h0, mk(1'b0, 32'h11223344, 5, 0, 4'b0, 32'h0, 0));

    // Byte store with replication, signed and unsigned byte loads.
    single("sb", 1'b1, 3'd0, 32'hD, 32'h123456AB, mk(1'b0, 32'h0, 5, 4, 4'b0010, 32'hABABABAB, 3));
    single("lb", 1'b0, 3'd0, 32'hD, 32'h0, mk(1'b0, 32'hFFFFFFAB, 5, 0, 4'b0, 32'h0, 0));
    single("lbu", 1'b0, 3'd4, 32'hD, 32'h0, mk(1'b0, 32'h000000AB, 5, 0, 4'b0, 32'h0, 0));

    // Upper-half halfword store, signed and unsigned halfword loads.
    single("sh", 1'b1, 3'd1, 32'h12, 32'hDEAD8001, mk(1'b0, 32'h0, 5, 4, 4'b1100, 32'h80018001, 4));
    single("lh", 1'b0, 3'd1, 32'h12, 32'h0, mk(1'b0, 32'hFFFF8001, 5, 0, 4'b0, 32'h0, 0));
    single("lhu", 1'b0, 3'd5, 32'h12, 32'h0, mk(1'b0, 32'h00008001, 5, 0, 4'b0, 32'h0, 0));

    // Illegal requests: respond one cycle after accept, memory untouched.
    single("err_lw6", 1'b0, 3'd2, 32'h6, 32'h0, mk(1'b1, 32'h0, 1, 0, 4'b0, 32'h0, 0));
    single("err_sh3", 1'b1, 3'd1, 32'h3, 32'hFFFF, mk(1'b1, 32'h0, 1, 0, 4'b0, 32'h0, 0));
    single("err_f3", 1'b0, 3'd3, 32'h0, 32'h0, mk(1'b1, 32'h0, 1, 0, 4'b0, 32'h0, 0));
    single("err_sbu", 1'b1, 3'd4, 32'h4, 32'h55, mk(1'b1, 32'h0, 1, 0, 4'b0, 32'h0, 0));

    // Back-to-back with req_valid held high throughout.
    present(1'b1, 3'd2, 32'h40, 32'hCAFEF00D);
    wait_accept("b2b_sw", mk(1'b0, 32'h0, 5, 4, 4'b1111, 32'hCAFEF00D, 16), 1'b1);
    present(1'b0, 3'd2, 32'h40, 32'h0);
    wait_resp("b2b_sw");
    wait_accept("b2b_lw", mk(1'b0, 32'hCAFEF00D, 5, 0, 4'b0, 32'h0, 0), 1'b1);
    present(1'b0, 3'd0, 32'h43, 32'h0);
    wait_resp("b2b_lw");
    wait_accept("b2b_lb", mk(1'b0, 32'hFFFFFFCA, 5, 0, 4'b0, 32'h0, 0), 1'b1);
    present(1'b0, 3'd2, 32'h41, 32'h0);
    wait_resp("b2b_lb");
    wait_accept("b2b_err", mk(1'b1, 32'h0, 1, 0, 4'b0, 32'h0, 0), 1'b1);
    req_valid = 1'b0;
    wait_resp("b2b_err");

    // Reset on the second write-hold cycle aborts the store with no response.
    present(1'b1, 3'd2, 32'h20, 32'h99999999);
    wait_accept("rst_sw", mk(1'b0, 32'h0, 5, 4, 4'b1111, 32'h99999999, 8), 1'b0);
    req_valid = 1'b0;
    check("rst_sw wren_first", 32'(mem_wren), 32'd1);
    @(posedge clk);
    #1;
    check("rst_sw wren_second", 32'(mem_wren), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst wren", 32'(mem_wren), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("midrst no_resp", 32'(pulses), 32'd0);

    // Unit recovers after the abort.
    single("lw_after_rst", 1'b0, 3'd2, 32'h8, 32'h0, mk(1'b0, 32'h11223344, 5, 0, 4'b0, 32'h0, 0));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
